// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-level AXI4-Stream arbiter.
package logic_axi4_stream_packet_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Width of an index into a vector of n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_packet_arbiter_rr.sv
// Combinational round-robin picker: searches upward from the input after
// last_owner, wrapping around, and reports the first requesting index.
module logic_axi4_stream_packet_arbiter_rr
    import logic_axi4_stream_packet_arbiter_pkg::*;
#(
    parameter int INPUTS = 4,
    localparam int IDX_W = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    input  logic [IDX_W-1:0]  last_owner,
    output logic              found,
    output logic [IDX_W-1:0]  winner
);

    int               cand_sum;
    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order; the first hit wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand_sum = 0;
        cand     = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            cand_sum = int'(last_owner) + k;
            if (cand_sum >= INPUTS) begin
                cand_sum = cand_sum - INPUTS;
            end
            cand = IDX_W'(cand_sum);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one registered AXI4-Stream output
// among INPUTS requesters. A winner keeps the grant until its last beat is
// accepted, so packets from different inputs are never interleaved.
module logic_axi4_stream_packet_arbiter
    import logic_axi4_stream_packet_arbiter_pkg::*;
#(
    parameter int INPUTS      = 4,
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [INPUTS-1:0]                        rx_tvalid,
    input  logic [INPUTS-1:0]                        rx_tlast,
    input  logic [INPUTS-1:0][TDATA_BYTES-1:0][7:0]  rx_tdata,
    input  logic [INPUTS-1:0][TDATA_BYTES-1:0]       rx_tstrb,
    input  logic [INPUTS-1:0][TDATA_BYTES-1:0]       rx_tkeep,
    input  logic [INPUTS-1:0][TDEST_WIDTH-1:0]       rx_tdest,
    input  logic [INPUTS-1:0][TUSER_WIDTH-1:0]       rx_tuser,
    input  logic [INPUTS-1:0][TID_WIDTH-1:0]         rx_tid,
    output logic [INPUTS-1:0]                        rx_tready,
    output logic                                     tx_tvalid,
    output logic                                     tx_tlast,
    output logic [TDATA_BYTES-1:0][7:0]              tx_tdata,
    output logic [TDATA_BYTES-1:0]                   tx_tstrb,
    output logic [TDATA_BYTES-1:0]                   tx_tkeep,
    output logic [TDEST_WIDTH-1:0]                   tx_tdest,
    output logic [TUSER_WIDTH-1:0]                   tx_tuser,
    output logic [TID_WIDTH-1:0]                     tx_tid,
    input  logic                                     tx_tready,
    output logic [INPUTS-1:0]                        grant
);

    localparam int IDX_W = idx_width(INPUTS);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] owner_d;
    logic [IDX_W-1:0] last_owner_q;
    logic [IDX_W-1:0] last_owner_d;

    logic             rr_found;
    logic [IDX_W-1:0] rr_winner;

    logic             out_free;
    logic             accept;
    logic             accept_last;

    logic_axi4_stream_packet_arbiter_rr #(
        .INPUTS(INPUTS)
    ) u_rr (
        .req       (rx_tvalid),
        .last_owner(last_owner_q),
        .found     (rr_found),
        .winner    (rr_winner)
    );

    assign out_free    = !tx_tvalid || tx_tready;
    assign accept      = (state_q == LOCKED) && rx_tvalid[owner_q] && out_free;
    assign accept_last = (USE_TLAST != 0) ? rx_tlast[owner_q] : 1'b1;

    // One-hot owner while locked; ready follows the grant only when the output slot can take a beat.
    always_comb begin
        grant = '0;
        if (state_q == LOCKED) begin
            grant[owner_q] = 1'b1;
        end
        rx_tready = out_free ? grant : '0;
    end

    // Arbitration state, current owner and the priority pointer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(INPUTS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Lock onto the round-robin winner in IDLE; release after the owner's last beat.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    owner_d = rr_winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && accept_last) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on an accepted beat, otherwise drain when downstream is ready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            tx_tdata  <= '0;
            tx_tstrb  <= '0;
            tx_tkeep  <= '0;
            tx_tdest  <= '0;
            tx_tuser  <= '0;
            tx_tid    <= '0;
        end else if (accept) begin
            tx_tvalid <= 1'b1;
            tx_tlast  <= accept_last;
            tx_tdata  <= rx_tdata[owner_q];
            tx_tstrb  <= (USE_TSTRB != 0) ? rx_tstrb[owner_q] : '1;
            tx_tkeep  <= (USE_TKEEP != 0) ? rx_tkeep[owner_q] : '1;
            tx_tdest  <= rx_tdest[owner_q];
            tx_tuser  <= rx_tuser[owner_q];
            tx_tid    <= rx_tid[owner_q];
        end else if (tx_tready) begin
            tx_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Self-checking bench for the packet arbiter: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with hand-computed beat orders.
module tb_logic_axi4_stream_packet_arbiter;

    localparam int N = 4;

    logic aclk = 1'b0;
    logic areset;

    logic [N-1:0]           rx_tvalid;
    logic [N-1:0]           rx_tlast;
    logic [N-1:0][3:0][7:0] rx_tdata;
    logic [N-1:0][3:0]      rx_tstrb;
    logic [N-1:0][3:0]      rx_tkeep;
    logic [N-1:0][0:0]      rx_tdest;
    logic [N-1:0][0:0]      rx_tuser;
    logic [N-1:0][0:0]      rx_tid;

    logic [N-1:0] a_rx_tready, a_grant;
    logic         a_tvalid, a_tlast, a_tready;
    logic [3:0][7:0] a_tdata;
    logic [3:0]   a_tstrb, a_tkeep;
    logic [0:0]   a_tdest, a_tuser, a_tid;

    logic [N-1:0] b_rx_tready, b_grant;
    logic         b_tvalid, b_tlast, b_tready;
    logic [3:0][7:0] b_tdata;
    logic [3:0]   b_tstrb, b_tkeep;
    logic [0:0]   b_tdest, b_tuser, b_tid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit use_b = 1'b0;
    bit tready_pat[$];

    int src_left[N];
    int src_len[N];
    int src_beat[N];
    int src_pkt[N];
    bit src_hold[N];

    typedef struct {
        bit         locked;
        logic [1:0] owner;
        logic [1:0] last_owner;
        logic       tv;
        logic       tl;
        logic [31:0] td;
        logic [3:0] ts;
        logic [3:0] tk;
        logic       tdest;
        logic       tuser;
        logic       tid;
    } model_t;

    typedef struct {
        int src;
        int beat;
        bit last;
        int cyc;
    } beat_t;

    model_t ma, mb;
    beat_t  log_a[$];
    beat_t  log_b[$];

    logic_axi4_stream_packet_arbiter #(
        .INPUTS(N), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1),
        .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
    ) dut_a (
        .aclk(aclk), .areset(areset),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest),
        .rx_tuser(rx_tuser), .rx_tid(rx_tid), .rx_tready(a_rx_tready),
        .tx_tvalid(a_tvalid), .tx_tlast(a_tlast), .tx_tdata(a_tdata),
        .tx_tstrb(a_tstrb), .tx_tkeep(a_tkeep), .tx_tdest(a_tdest),
        .tx_tuser(a_tuser), .tx_tid(a_tid), .tx_tready(a_tready), .grant(a_grant)
    );

    logic_axi4_stream_packet_arbiter #(
        .INPUTS(N), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1),
        .USE_TLAST(0), .USE_TKEEP(1), .USE_TSTRB(1)
    ) dut_b (
        .aclk(aclk), .areset(areset),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest),
        .rx_tuser(rx_tuser), .rx_tid(rx_tid), .rx_tready(b_rx_tready),
        .tx_tvalid(b_tvalid), .tx_tlast(b_tlast), .tx_tdata(b_tdata),
        .tx_tstrb(b_tstrb), .tx_tkeep(b_tkeep), .tx_tdest(b_tdest),
        .tx_tuser(b_tuser), .tx_tid(b_tid), .tx_tready(b_tready), .grant(b_grant)
    );

    always #5 aclk = ~aclk;

    // Compare one observed value with its expectation and count the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic model_t model_reset();
        model_t r;
        r.locked = 1'b0; r.owner = 2'd0; r.last_owner = 2'(N - 1);
        r.tv = 1'b0; r.tl = 1'b0; r.td = '0; r.ts = '0; r.tk = '0;
        r.tdest = 1'b0; r.tuser = 1'b0; r.tid = 1'b0;
        return r;
    endfunction

    // One clock of the arbiter's documented behaviour, in terms of owner indices and beats.
    function automatic model_t model_step(input model_t m, input bit use_tlast, input bit rst, input bit txr);
        model_t n;
        logic [1:0] c;
        bool_found: begin end
        n = m;
        if (rst) return model_reset();
        if (!m.locked) begin
            for (int j = 1; j <= N; j++) begin
                c = 2'((int'(m.last_owner) + j) % N);
                if (!n.locked && rx_tvalid[c]) begin
                    n.locked = 1'b1;
                    n.owner  = c;
                end
            end
            if (txr) n.tv = 1'b0;
        end else if (rx_tvalid[m.owner] && (!m.tv || txr)) begin
            n.tv    = 1'b1;
            n.tl    = use_tlast ? rx_tlast[m.owner] : 1'b1;
            n.td    = rx_tdata[m.owner];
            n.ts    = rx_tstrb[m.owner];
            n.tk    = rx_tkeep[m.owner];
            n.tdest = rx_tdest[m.owner][0];
            n.tuser = rx_tuser[m.owner][0];
            n.tid   = rx_tid[m.owner][0];
            if (n.tl) begin
                n.locked     = 1'b0;
                n.last_owner = m.owner;
            end
        end else if (txr) begin
            n.tv = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [3:0] m_grant(input model_t m);
        return m.locked ? (4'b0001 << m.owner) : 4'b0000;
    endfunction

    function automatic logic [3:0] m_ready(input model_t m, input bit txr);
        return (m.locked && (!m.tv || txr)) ? m_grant(m) : 4'b0000;
    endfunction

    // Advance both reference models on every rising edge.
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        ma  <= model_step(ma, 1'b1, areset, a_tready);
        mb  <= model_step(mb, 1'b0, areset, b_tready);
    end

    // Check both DUTs against their models mid-cycle and log delivered beats.
    always @(negedge aclk) begin
        if (chk_en) begin
            beat_t e;
            checkOutput("a_tvalid", a_tvalid, ma.tv);
            checkOutput("a_grant", a_grant, m_grant(ma));
            checkOutput("a_rx_tready", a_rx_tready, m_ready(ma, a_tready));
            checkOutput("a_tlast", a_tlast, ma.tl);
            checkOutput("a_tdata", a_tdata, ma.td);
            checkOutput("a_tstrb", a_tstrb, ma.ts);
            checkOutput("a_tkeep", a_tkeep, ma.tk);
            checkOutput("a_side", {a_tdest, a_tuser, a_tid}, {ma.tdest, ma.tuser, ma.tid});
            checkOutput("b_tvalid", b_tvalid, mb.tv);
            checkOutput("b_grant", b_grant, m_grant(mb));
            checkOutput("b_rx_tready", b_rx_tready, m_ready(mb, b_tready));
            checkOutput("b_tlast", b_tlast, mb.tl);
            checkOutput("b_tdata", b_tdata, mb.td);
            checkOutput("b_side", {b_tstrb, b_tkeep, b_tdest, b_tuser, b_tid},
                        {mb.ts, mb.tk, mb.tdest, mb.tuser, mb.tid});
            if (a_tvalid && a_tready) begin
                e.src = int'(a_tdata[3]); e.beat = int'(a_tdata[1]); e.last = a_tlast; e.cyc = cyc;
                log_a.push_back(e);
            end
            if (b_tvalid && b_tready) begin
                e.src = int'(b_tdata[3]); e.beat = int'(b_tdata[1]); e.last = b_tlast; e.cyc = cyc;
                log_b.push_back(e);
            end
        end
    end

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            logic [7:0] b;
            b = 8'(src_beat[i]);
            rx_tvalid[i] = (src_left[i] > 0) && !src_hold[i];
            rx_tlast[i]  = (src_beat[i] == src_len[i] - 1);
            rx_tdata[i]  = {8'(i), 8'(src_pkt[i]), b, 8'h5A ^ b};
            rx_tkeep[i]  = rx_tlast[i] ? 4'b0111 : 4'b1111;
            rx_tstrb[i]  = 4'(i + src_beat[i]) | 4'b0001;
            rx_tdest[i]  = 1'(i >> 1);
            rx_tuser[i]  = b[0];
            rx_tid[i]    = 1'(i);
        end
    endtask

    task automatic set_source(input int i, input int pkts, input int len);
        src_left[i] = pkts; src_len[i] = len; src_beat[i] = 0; src_pkt[i] = 0; src_hold[i] = 1'b0;
    endtask

    // Run a number of clocks; sources advance on handshakes seen just before each edge.
    task automatic applyStimulus(input int cycles);
        logic [N-1:0] hs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge aclk);
            hs = rx_tvalid & (use_b ? b_rx_tready : a_rx_tready);
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if (src_beat[i] == src_len[i] - 1) begin
                        src_beat[i] = 0; src_pkt[i]++; src_left[i]--;
                    end else begin
                        src_beat[i]++;
                    end
                end
            end
            a_tready = (tready_pat.size() > 0) ? tready_pat.pop_front() : 1'b1;
            drive_sources();
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) set_source(i, 0, 1);
        drive_sources();
        areset = 1'b1;
        applyStimulus(2);
        areset = 1'b0;
    endtask

    task automatic check_beat(input string tag, input beat_t q[$], input int k,
                              input int src, input int beat, input bit last);
        if (k >= q.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s beat %0d missing: logged=%0d required>%0d", tag, k, q.size(), k);
        end else begin
            checkOutput($sformatf("%s_src%0d", tag, k), q[k].src, src);
            checkOutput($sformatf("%s_beat%0d", tag, k), q[k].beat, beat);
            checkOutput($sformatf("%s_last%0d", tag, k), q[k].last, last);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p2_src[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int p6_src[4]  = '{0, 0, 1, 1};
        a_tready = 1'b1;
        b_tready = 1'b1;
        ma = model_reset();
        mb = model_reset();
        do_reset();
        chk_en = 1'b1;
        #1;
        checkOutput("rst_tvalid", a_tvalid, 1'b0);
        checkOutput("rst_grant", a_grant, 4'b0000);
        checkOutput("rst_rx_tready", a_rx_tready, 4'b0000);
        checkOutput("rst_fields", {a_tlast, a_tdata, a_tstrb, a_tkeep, a_tdest, a_tuser, a_tid}, '0);

        $display("[TB] scenario 1: single 3-beat packet from input 0");
        log_a.delete();
        set_source(0, 1, 3);
        drive_sources();
        applyStimulus(1);
        #1;
        checkOutput("p1_grant_locked", a_grant, 4'b0001);
        applyStimulus(3);
        #1;
        checkOutput("p1_grant_released", a_grant, 4'b0000);
        checkOutput("p1_tlast_third", {a_tvalid, a_tlast}, 2'b11);
        applyStimulus(2);
        checkOutput("p1_count", log_a.size(), 3);
        for (int k = 0; k < 3; k++) check_beat("p1", log_a, k, 0, k, k == 2);
        if (log_a.size() >= 3) checkOutput("p1_back_to_back", log_a[2].cyc - log_a[0].cyc, 2);

        $display("[TB] scenario 2: four inputs, round-robin over 2-beat packets");
        do_reset();
        log_a.delete();
        set_source(0, 2, 2);
        for (int i = 1; i < N; i++) set_source(i, 1, 2);
        drive_sources();
        applyStimulus(20);
        checkOutput("p2_count", log_a.size(), 10);
        for (int k = 0; k < 10; k++) check_beat("p2", log_a, k, p2_src[k], k % 2, (k % 2) == 1);

        $display("[TB] scenario 3: downstream stalls mid-packet on input 2");
        do_reset();
        log_a.delete();
        set_source(2, 1, 4);
        drive_sources();
        applyStimulus(1);
        tready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(2);
        #1;
        checkOutput("p3_stall_ready", a_rx_tready, 4'b0000);
        checkOutput("p3_stall_beat", {a_tvalid, a_tdata[1]}, {1'b1, 8'd1});
        applyStimulus(1);
        #1;
        checkOutput("p3_hold_ready", a_rx_tready, 4'b0000);
        checkOutput("p3_hold_beat", {a_tvalid, a_tdata[1]}, {1'b1, 8'd1});
        applyStimulus(6);
        checkOutput("p3_count", log_a.size(), 4);
        for (int k = 0; k < 4; k++) check_beat("p3", log_a, k, 2, k, k == 3);

        $display("[TB] scenario 4: owner 1 pauses while input 3 waits");
        do_reset();
        log_a.delete();
        set_source(1, 1, 3);
        drive_sources();
        applyStimulus(2);
        src_hold[1] = 1'b1;
        set_source(3, 1, 2);
        drive_sources();
        for (int h = 0; h < 5; h++) begin
            applyStimulus(1);
            #1;
            checkOutput("p4_grant_held", a_grant, 4'b0010);
        end
        src_hold[1] = 1'b0;
        drive_sources();
        applyStimulus(3);
        #1;
        checkOutput("p4_grant_moved", a_grant, 4'b1000);
        applyStimulus(6);
        checkOutput("p4_count", log_a.size(), 5);
        for (int k = 0; k < 3; k++) check_beat("p4", log_a, k, 1, k, k == 2);
        for (int k = 0; k < 2; k++) check_beat("p4", log_a, k + 3, 3, k, k == 1);

        $display("[TB] scenario 5: tlast ignored, inputs 0 and 1 alternate per beat");
        use_b = 1'b1;
        do_reset();
        log_b.delete();
        set_source(0, 3, 2);
        set_source(1, 3, 2);
        drive_sources();
        applyStimulus(1);
        #1;
        checkOutput("p5_grant_first", b_grant, 4'b0001);
        applyStimulus(2);
        #1;
        checkOutput("p5_grant_second", b_grant, 4'b0010);
        applyStimulus(12);
        for (int k = 0; k < 4; k++) check_beat("p5", log_b, k, k % 2, (k / 2) % 2, 1'b1);
        use_b = 1'b0;

        $display("[TB] scenario 6: reset while locked with a beat registered");
        do_reset();
        log_a.delete();
        set_source(2, 1, 4);
        drive_sources();
        applyStimulus(2);
        #1;
        checkOutput("p6_pre_state", {a_tvalid, a_grant}, {1'b1, 4'b0100});
        areset = 1'b1;
        set_source(2, 0, 1);
        set_source(0, 1, 2);
        set_source(1, 1, 2);
        drive_sources();
        applyStimulus(1);
        #1;
        checkOutput("p6_rst_state", {a_tvalid, a_grant, a_rx_tready}, 9'b0);
        areset = 1'b0;
        log_a.delete();
        applyStimulus(1);
        #1;
        checkOutput("p6_first_winner", a_grant, 4'b0001);
        applyStimulus(10);
        checkOutput("p6_count", log_a.size(), 4);
        for (int k = 0; k < 4; k++) check_beat("p6", log_a, k, p6_src[k], k % 2, (k % 2) == 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
